ddr_init_scrubber: RTL and testbench



---
 rtl/ddr_init_scrubber.sv | 158 +++++++++++++++
 tb/tb_ddr_init_scrubber.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_init_scrubber.sv
// Zero-fills a DDR region through its own AXI write master once calibration completes, then releases the port.
// Scrubbing is compiled in only when DDR_SCRUB_EN is defined; otherwise the port is released right after calibration.
module ddr_init_scrubber #(
    parameter int          AXI_ADDR_WIDTH  = 64,
    parameter int          AXI_DATA_WIDTH  = 64,
    parameter int          AXI_ID_WIDTH    = 10,
    parameter logic [63:0] BASE_ADDR       = 64'h0,
    parameter logic [63:0] SCRUB_BYTES     = 64'h2000_0000,
    parameter int          BURST_LEN       = 16,
    parameter int          MAX_OUTSTANDING = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        calib_done_i,
    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [7:0]                  aw_len_o,
    output logic [2:0]                  aw_size_o,
    output logic [1:0]                  aw_burst_o,
    output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
    output logic                        w_last_o,
    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    input  logic [1:0]                  b_resp_i,
    output logic                        release_o,
    output logic                        busy_o,
    output logic                        err_o
);
    typedef enum logic [1:0] {WAIT_CAL, SCRUB, DRAIN, DONE} state_t;

    localparam int          BURST_BYTES = BURST_LEN * AXI_DATA_WIDTH / 8;
    localparam logic [63:0] NUM_BURSTS  = SCRUB_BYTES / 64'(BURST_BYTES);

    state_t state;

    assign aw_len_o   = 8'(BURST_LEN - 1);
    assign aw_size_o  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign aw_burst_o = 2'b01;
    assign aw_id_o    = '0;
    assign w_data_o   = '0;
    assign w_strb_o   = '1;

`ifdef DDR_SCRUB_EN
    localparam int                        CNT_W     = $clog2(NUM_BURSTS + 64'd1);
    localparam int                        BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]          NB        = CNT_W'(NUM_BURSTS);
    localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [3:0]                MAX_OUT   = 4'(MAX_OUTSTANDING);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP = AXI_ADDR_WIDTH'(BURST_BYTES);

    logic [CNT_W-1:0]  aw_cnt, aw_cnt_nx, w_burst, w_burst_nx;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_nx;
    logic [3:0]        outstanding, outst_nx;
    logic              aw_hs, w_hs, b_hs, b_err, beat_end;

    // Next-state counters include this cycle's handshakes so the registered
    // valids are correct on the very next cycle without looking at ready.
    always_comb begin
        aw_hs       = aw_valid_o & aw_ready_i;
        w_hs        = w_valid_o & w_ready_i;
        b_hs        = b_valid_i & b_ready_o;
        b_err       = b_hs && (b_resp_i != 2'b00);
        beat_end    = (beat_cnt == LAST_BEAT);
        aw_cnt_nx   = aw_cnt + CNT_W'(aw_hs);
        w_burst_nx  = w_burst + CNT_W'(w_hs && beat_end);
        outst_nx    = outstanding + 4'(aw_hs) - 4'(b_hs);
        beat_cnt_nx = beat_cnt;
        if (w_hs)
            beat_cnt_nx = beat_end ? '0 : beat_cnt + BEAT_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= WAIT_CAL;
            aw_cnt      <= '0;
            w_burst     <= '0;
            beat_cnt    <= '0;
            outstanding <= '0;
            aw_valid_o  <= 1'b0;
            aw_addr_o   <= '0;
            w_valid_o   <= 1'b0;
            w_last_o    <= 1'b0;
            b_ready_o   <= 1'b0;
            release_o   <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                WAIT_CAL: if (calib_done_i) begin
                    state      <= SCRUB;
                    aw_valid_o <= 1'b1;
                    aw_addr_o  <= AXI_ADDR_WIDTH'(BASE_ADDR);
                    w_last_o   <= (BURST_LEN == 1);
                    b_ready_o  <= 1'b1;
                    busy_o     <= 1'b1;
                end
                SCRUB: begin
                    aw_cnt      <= aw_cnt_nx;
                    w_burst     <= w_burst_nx;
                    beat_cnt    <= beat_cnt_nx;
                    outstanding <= outst_nx;
                    err_o       <= err_o | b_err;
                    w_last_o    <= (beat_cnt_nx == LAST_BEAT);
                    if (aw_hs)
                        aw_addr_o <= aw_addr_o + ADDR_STEP;
                    // All W beats done implies all AWs were accepted before them.
                    if (w_burst_nx == NB) begin
                        state      <= DRAIN;
                        aw_valid_o <= 1'b0;
                        w_valid_o  <= 1'b0;
                    end else begin
                        aw_valid_o <= (aw_cnt_nx < NB) && (outst_nx < MAX_OUT);
                        w_valid_o  <= (w_burst_nx < aw_cnt_nx);
                    end
                end
                DRAIN: begin
                    outstanding <= outst_nx;
                    err_o       <= err_o | b_err;
                    if (outst_nx == '0) begin
                        state     <= DONE;
                        b_ready_o <= 1'b0;
                        busy_o    <= 1'b0;
                        release_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{aw_ready_i, w_ready_i, b_valid_i, b_resp_i, NUM_BURSTS, BASE_ADDR,
                          4'(MAX_OUTSTANDING)};

    assign aw_valid_o = 1'b0;
    assign aw_addr_o  = '0;
    assign w_valid_o  = 1'b0;
    assign w_last_o   = 1'b0;
    assign b_ready_o  = 1'b0;
    assign busy_o     = 1'b0;
    assign err_o      = 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= WAIT_CAL;
            release_o <= 1'b0;
        end else if (state == WAIT_CAL && calib_done_i) begin
            state     <= DONE;
            release_o <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ddr_init_scrubber.sv
// Directed bench for ddr_init_scrubber: 1 KiB region at 0x8000_0000, 16-beat bursts of 64-bit data.
// Runs the full scrub scenarios when DDR_SCRUB_EN is defined, otherwise the pass-through release.
module tb_ddr_init_scrubber;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i = 1'b1, calib_done_i = 1'b0;
    logic        aw_ready_i = 1'b0, w_ready_i = 1'b0, b_valid_i = 1'b0;
    logic [1:0]  b_resp_i = 2'b00;
    logic        aw_valid_o, w_valid_o, w_last_o, b_ready_o, release_o, busy_o, err_o;
    logic [63:0] aw_addr_o;
    logic [7:0]  aw_len_o;
    logic [2:0]  aw_size_o;
    logic [1:0]  aw_burst_o;
    logic [9:0]  aw_id_o;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;

    ddr_init_scrubber #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(10),
        .BASE_ADDR(BASE), .SCRUB_BYTES(64'd1024), .BURST_LEN(16), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .calib_done_i(calib_done_i),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o), .aw_id_o(aw_id_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o), .w_strb_o(w_strb_o),
        .w_last_o(w_last_o), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .release_o(release_o), .busy_o(busy_o), .err_o(err_o)
    );

    int n_cmp = 0, n_fail = 0;
    bit stall = 1'b0, b_en = 1'b1;
    int err_burst = -1;

    // Slave/monitor bookkeeping, cleared by the same reset as the DUT.
    int cyc = 0, n_aw = 0, n_w = 0, n_b = 0, b_owed = 0, beats = 0, w_bursts = 0;
    int stab_err = 0, last_err = 0, order_err = 0, valid_seen = 0;
    int first_w = -1, last_w = -1, first_b = -1, last_b = -1, aw_resume = -1;
    int rel_cyc = -1, b3_cyc = -1, err_cyc = -1;
    bit aw_hold = 1'b0, w_hold = 1'b0, w_last_q = 1'b0;
    logic [63:0] aw_addr_q = '0;
    logic [63:0] aw_addrs [16];

    always @(posedge clk) begin
        cyc++;
        if (rst_i) begin
            n_aw = 0; n_w = 0; n_b = 0; b_owed = 0; beats = 0; w_bursts = 0;
            stab_err = 0; last_err = 0; order_err = 0; valid_seen = 0;
            first_w = -1; last_w = -1; first_b = -1; last_b = -1; aw_resume = -1;
            rel_cyc = -1; b3_cyc = -1; err_cyc = -1; aw_hold = 1'b0; w_hold = 1'b0;
        end else begin
            if (aw_valid_o || w_valid_o) valid_seen++;
            if (aw_hold && (!aw_valid_o || aw_addr_o != aw_addr_q)) stab_err++;
            if (w_hold && (!w_valid_o || w_last_o != w_last_q)) stab_err++;
            aw_hold = aw_valid_o && !aw_ready_i; aw_addr_q = aw_addr_o;
            w_hold = w_valid_o && !w_ready_i;    w_last_q = w_last_o;
            if (w_valid_o && w_ready_i) begin
                if (w_bursts >= n_aw) order_err++;
                if (first_w < 0) first_w = cyc;
                last_w = cyc;
                n_w++;
                if (w_last_o != (beats == 15)) last_err++;
                if (w_last_o) begin beats = 0; w_bursts++; b_owed++; end
                else beats++;
            end
            if (aw_valid_o && aw_ready_i) begin
                if (n_aw < 16) aw_addrs[n_aw] = aw_addr_o;
                n_aw++;
            end
            if (b_valid_i && b_ready_o) begin
                if (n_b == 3) b3_cyc = cyc;
                if (first_b < 0) first_b = cyc;
                last_b = cyc;
                n_b++; b_owed--;
            end
            if (first_b >= 0 && aw_resume < 0 && aw_valid_o && cyc > first_b) aw_resume = cyc;
            if (release_o && rel_cyc < 0) rel_cyc = cyc;
            if (err_o && err_cyc < 0) err_cyc = cyc;
        end
    end

    always @(posedge clk) begin
        #1;
        aw_ready_i = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        w_ready_i  = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        b_valid_i  = b_en && (b_owed > 0);
        b_resp_i   = (b_valid_i && n_b == err_burst) ? 2'b10 : 2'b00;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; calib_done_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic wait_release(input int budget);
        int k;
        k = 0;
        while (release_o !== 1'b1 && k < budget) begin @(negedge clk); k++; end
        chk("release_timeout", release_o, 1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (n_w < n && k < budget) begin @(negedge clk); k++; end
    endtask

    task automatic check_consts();
        chk("aw_len", aw_len_o, 15);
        chk("aw_size", aw_size_o, 3);
        chk("aw_burst", aw_burst_o, 1);
        chk("aw_id", aw_id_o, 0);
        chk("w_data", w_data_o, 0);
        chk("w_strb", w_strb_o, 8'hff);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_outs", {aw_valid_o, w_valid_o, w_last_o, b_ready_o, release_o, busy_o, err_o}, 0);
        chk("reset_addr", aw_addr_o, 0);
        check_consts();
        repeat (5) @(negedge clk);
        chk("idle_no_cal", {aw_valid_o, w_valid_o, busy_o, release_o}, 0);
`ifdef DDR_SCRUB_EN
        // Full scrub, all readies high
        calib_done_i = 1'b1;
        @(negedge clk);
        chk("first_aw", {aw_valid_o, w_valid_o, busy_o, b_ready_o}, 4'b1011);
        chk("first_aw_addr", aw_addr_o, BASE);
        @(negedge clk);
        calib_done_i = 1'b0;
        chk("first_w_valid", w_valid_o, 1);
        chk("second_aw_addr", aw_addr_o, BASE + 64'h80);
        wait_release(600);
        chk("t1_aw_count", n_aw, 8);
        for (int i = 0; i < 8; i++) chk("t1_aw_addr", aw_addrs[i], BASE + 64'(i) * 64'h80);
        chk("t1_w_beats", n_w, 128);
        chk("t1_b_count", n_b, 8);
        chk("t1_wlast_pos", last_err, 0);
        chk("t1_w_order", order_err, 0);
        chk("t1_w_rate", last_w - first_w, 127);
        chk("t1_release_lag", rel_cyc - last_b, 1);
        chk("t1_final_outs", {aw_valid_o, w_valid_o, b_ready_o, busy_o, err_o, release_o}, 6'b000001);

        // B withheld: AW issue caps at four outstanding
        do_reset();
        b_en = 1'b0; calib_done_i = 1'b1;
        repeat (80) @(negedge clk);
        chk("t2_aw_capped", n_aw, 4);
        chk("t2_aw_valid_low", aw_valid_o, 0);
        chk("t2_w_beats", n_w, 64);
        chk("t2_w_valid_low", w_valid_o, 0);
        chk("t2_busy", {busy_o, release_o}, 2'b10);
        b_en = 1'b1;
        wait_release(600);
        chk("t2_aw_resume", aw_resume - first_b, 1);
        chk("t2_aw_count", n_aw, 8);
        chk("t2_err", err_o, 0);

        // Random ready stalls
        do_reset();
        stall = 1'b1; calib_done_i = 1'b1;
        wait_release(3000);
        stall = 1'b0;
        chk("t3_stable", stab_err, 0);
        chk("t3_wlast_pos", last_err, 0);
        chk("t3_w_order", order_err, 0);
        chk("t3_w_beats", n_w, 128);
        chk("t3_aw_count", n_aw, 8);
        chk("t3_aw_last_addr", aw_addrs[7], BASE + 64'h380);

        // SLVERR on burst 3
        do_reset();
        err_burst = 3; calib_done_i = 1'b1;
        wait_release(600);
        err_burst = -1;
        chk("t4_err_sticky", err_o, 1);
        chk("t4_err_timing", err_cyc - b3_cyc, 1);
        chk("t4_b_count", n_b, 8);
        chk("t4_w_beats", n_w, 128);

        // Reset mid-burst on W beat 40
        do_reset();
        chk("t5_err_cleared", err_o, 0);
        calib_done_i = 1'b1;
        wait_beats(40, 200);
        chk("t5_beat40", n_w, 40);
        chk("t5_midburst", w_valid_o, 1);
        rst_i = 1'b1;
        @(negedge clk);
        chk("t5_reset_outs", {aw_valid_o, w_valid_o, w_last_o, b_ready_o, release_o, busy_o, err_o}, 0);
        chk("t5_reset_addr", aw_addr_o, 0);
        rst_i = 1'b0; calib_done_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_idle", {aw_valid_o, w_valid_o, busy_o, release_o}, 0);
        calib_done_i = 1'b1;
        @(negedge clk);
        chk("t5_restart_addr", aw_addr_o, BASE);
        wait_release(600);
        chk("t5_aw_count", n_aw, 8);
        chk("t5_aw_first", aw_addrs[0], BASE);
        chk("t5_w_beats", n_w, 128);
        chk("t5_err", err_o, 0);
`else
        calib_done_i = 1'b1;
        chk("dis_release_pre", release_o, 0);
        @(negedge clk);
        chk("dis_release", release_o, 1);
        chk("dis_outs", {aw_valid_o, w_valid_o, w_last_o, b_ready_o, busy_o, err_o}, 0);
        calib_done_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("dis_release_held", release_o, 1);
        chk("dis_no_valid", valid_seen, 0);
        chk("dis_no_aw", n_aw, 0);
        do_reset();
        chk("dis_reset_release", release_o, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
